// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one physical memory port between the instruction-fetch side (I) and
// the data side (D). One requester is granted at a time, and the grant is held
// until mem_resp. Under contention the two sides alternate, so neither side
// can starve the other.
//
// Handshake: each requester raises its request (i_read, or d_read/d_write) and
// holds it until its x_resp pulse. The arbiter samples requests only in IDLE.
// On the granting edge it latches the address, the write data and the op type.
// The memory side sees mem_read/mem_write as level strobes that stay up until
// the cycle in which mem_resp is high. x_resp and x_rdata are combinational
// in that same cycle, and the strobes drop on the following edge.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_resp,
    output logic              busy,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t state;
    logic   last_d;     // 1 when the most recently completed transaction was D
    logic   d_req;
    logic   grant_i;
    logic   grant_d;

    // Arbitration decision, used only while IDLE.
    // A tie goes to the side that was not served last.
    always_comb begin
        d_req   = d_read | d_write;
        grant_i = i_read & (~d_req | last_d);
        grant_d = d_req & ~grant_i;
    end

    // Grant FSM. The memory strobes, address and write data are registered
    // copies taken at grant time, so requester changes mid-transaction are
    // ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            last_d      <= 1'b1;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_i) begin
                        state       <= SERVE_I;
                        mem_read    <= 1'b1;
                        mem_write   <= 1'b0;
                        mem_address <= i_address;
                        busy        <= 1'b1;
                    end else if (grant_d) begin
                        // Read together with write is illegal; the write wins.
                        state       <= SERVE_D;
                        mem_read    <= d_read & ~d_write;
                        mem_write   <= d_write;
                        mem_address <= d_address;
                        mem_wdata   <= d_wdata;
                        busy        <= 1'b1;
                    end
                end
                SERVE_I: begin
                    if (mem_resp) begin
                        state    <= IDLE;
                        last_d   <= 1'b0;
                        mem_read <= 1'b0;
                        busy     <= 1'b0;
                    end
                end
                SERVE_D: begin
                    if (mem_resp) begin
                        state     <= IDLE;
                        last_d    <= 1'b1;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    // Completion pulses follow mem_resp in the same cycle. Read data is a
    // plain pass-through, and consumers qualify it with their resp.
    always_comb begin
        i_resp    = (state == SERVE_I) & mem_resp;
        d_resp    = (state == SERVE_D) & mem_resp;
        i_rdata   = mem_rdata;
        d_rdata   = mem_rdata;
        state_dbg = state;
    end

`ifndef SYNTHESIS
    // Flag an illegal simultaneous read and write at the moment D is granted.
    always @(posedge clk) begin
        if (!rst && state == IDLE && grant_d)
            assert (!(d_read && d_write));
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter. It plays both requesters and the
// memory. A transaction-level model predicts which side is granted, what the
// memory port must show, and when each resp pulses.
module tb_mem_port_arbiter;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 256;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_read;
    logic [ADDR_W-1:0] i_address;
    logic [DATA_W-1:0] i_rdata;
    logic              i_resp;
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_address;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_resp;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_resp;
    logic              busy;
    logic [1:0]        state_dbg;

    int n_total = 0;
    int n_bad   = 0;

    // Model state: side in service (0 none, 1 I, 2 D) plus the values captured
    // when that service began.
    int                m_side;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic              m_wr;
    logic              m_last_d;
    logic              i_pend;
    logic              d_pend;
    int                n_i_served;
    int                n_d_served;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .busy(busy), .state_dbg(state_dbg)
    );

    // clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] rand_line();
        logic [DATA_W-1:0] v;
        for (int k = 0; k < DATA_W / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    // Compare every visible output against the model for the current cycle.
    task automatic check_outputs();
        chk("busy",      busy,      (m_side != 0));
        chk("mem_read",  mem_read,  (m_side == 1) || (m_side == 2 && !m_wr));
        chk("mem_write", mem_write, (m_side == 2) && m_wr);
        chk("i_resp",    i_resp,    (m_side == 1) && mem_resp);
        chk("d_resp",    d_resp,    (m_side == 2) && mem_resp);
        chk("i_rdata",   i_rdata,   mem_rdata);
        chk("d_rdata",   d_rdata,   mem_rdata);
        if (m_side != 0) chk("mem_address", mem_address, m_addr);
        if (m_side == 2 && m_wr) chk("mem_wdata", mem_wdata, m_wdata);
    endtask

    // One clock cycle: apply the model to the edge, drive new stimulus,
    // then check. re_pct is the chance that an idle requester starts a request.
    task automatic cycle(input int re_pct);
        logic ireq, dreq;
        @(posedge clk);
        #1;
        ireq = i_read;
        dreq = d_read | d_write;
        if (m_side != 0) begin
            if (mem_resp) begin
                if (m_side == 1) begin
                    i_pend = 0; i_read = 0; n_i_served++;
                end else begin
                    d_pend = 0; d_read = 0; d_write = 0; n_d_served++;
                end
                m_last_d = (m_side == 2);
                m_side   = 0;
            end
        end else if (ireq && (!dreq || m_last_d)) begin
            m_side = 1; m_addr = i_address; m_wr = 0;
        end else if (dreq) begin
            m_side = 2; m_addr = d_address; m_wdata = d_wdata; m_wr = d_write;
        end
        // requesters: hold requests, jitter the payload to exercise latching
        if (!i_pend && $urandom_range(99) < re_pct) begin
            i_pend = 1; i_read = 1;
        end
        if (!d_pend && $urandom_range(99) < re_pct) begin
            d_pend = 1;
            if ($urandom_range(1) == 1) d_write = 1; else d_read = 1;
        end
        i_address = $urandom;
        d_address = $urandom;
        d_wdata   = rand_line();
        // memory: random latency, occasional spurious resp while idle
        mem_resp  = (m_side != 0) ? ($urandom_range(2) == 0) : ($urandom_range(7) == 0);
        mem_rdata = rand_line();
        #1;
        check_outputs();
    endtask

    initial begin
        rst = 1'b1;
        i_read = 0; i_address = '0; d_read = 0; d_write = 0;
        d_address = '0; d_wdata = '0; mem_rdata = '0; mem_resp = 0;
        m_side = 0; m_addr = '0; m_wdata = '0; m_wr = 0; m_last_d = 1;
        i_pend = 0; d_pend = 0; n_i_served = 0; n_d_served = 0;

        // reset state
        #12;
        chk("rst_busy",      busy,        1'b0);
        chk("rst_mem_read",  mem_read,    1'b0);
        chk("rst_mem_write", mem_write,   1'b0);
        chk("rst_i_resp",    i_resp,      1'b0);
        chk("rst_d_resp",    d_resp,      1'b0);
        chk("rst_mem_addr",  mem_address, '0);
        chk("rst_mem_wdata", mem_wdata,   '0);
        @(negedge clk);
        rst = 1'b0;

        // first tie after reset: the fetch side wins
        i_read = 1; i_pend = 1; i_address = 32'h60;
        d_write = 1; d_pend = 1; d_address = 32'h100; d_wdata = rand_line();
        for (int c = 0; c < 1500; c++) cycle(40);

        // continuous contention: the two sides must alternate
        begin
            int i0, d0;
            i0 = n_i_served; d0 = n_d_served;
            for (int c = 0; c < 800; c++) cycle(100);
            chk("contention_balance", ((n_i_served - i0) - (n_d_served - d0) <= 1) &&
                ((n_d_served - d0) - (n_i_served - i0) <= 1), 1'b1);
        end

        // asynchronous reset in the middle of a fetch transaction
        begin
            int budget;
            budget = 0;
            while (!(m_side == 1 && !mem_resp) && budget < 200) begin
                cycle(100);
                budget++;
            end
            chk("reach_serve_i", budget < 200, 1'b1);
            #3;
            mem_resp = 0;
            rst = 1'b1;
            #1;
            chk("arst_mem_read", mem_read, 1'b0);
            chk("arst_busy",     busy,     1'b0);
            chk("arst_i_resp",   i_resp,   1'b0);
            chk("arst_d_resp",   d_resp,   1'b0);
            m_side = 0; m_last_d = 1;
            i_read = 1; i_pend = 1;
            d_read = 0; d_write = 1; d_pend = 1;
            #1;
            rst = 1'b0;
            cycle(0);
            chk("post_rst_grant_i", m_side, 1);
        end

        for (int c = 0; c < 600; c++) cycle(60);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
